// File: rtl/mu0_uart_tx_if.sv
// MU0 bus signals seen by the serial transmitter: address/data/strobes in,
// status word and select back out to the top-level read mux.
interface mu0_uart_tx_if;
   logic [11:0] Address;
   logic [15:0] Data_out;
   logic        Wr;
   logic        Rd;
   logic [15:0] Rd_data;
   logic        Sel;

   modport master (output Address, Data_out, Wr, Rd, input Rd_data, Sel);
   modport slave  (input Address, Data_out, Wr, Rd, output Rd_data, Sel);
endinterface

// File: rtl/mu0_uart_tx.sv
// Memory-mapped 8N1 serial transmitter on the MU0 bus with a small byte FIFO.
// Define UART_PARITY_EN to add an even-parity bit between the data and stop bits.
module mu0_uart_tx #(
   parameter logic [11:0] ADDR_DATA    = 12'hFF0,
   parameter logic [11:0] ADDR_STATUS  = 12'hFF1,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_AW      = 2
) (
   input  logic           Clk,
   input  logic           Reset,
   mu0_uart_tx_if.slave   bus,
   output logic           Tx,
   output logic           Busy
);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int BW    = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   logic [7:0]         fifo_mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_reg;
   logic [FIFO_AW-1:0] rd_ptr_reg;
   logic [FIFO_AW:0]   count_reg;
   logic               overflow_reg;
   state_t             state_reg;
   logic [BW-1:0]      baud_reg;
   logic [2:0]         bit_reg;
   logic [7:0]         shift_reg;
   logic               parity_reg;
   logic               tx_reg;

   logic       push_req;
   logic       push_ok;
   logic       pop;
   logic       status_rd;
   logic       full;
   logic       baud_done;
   logic [7:0] head;
   logic       unused_hi;

   assign push_req  = bus.Wr && (bus.Address == ADDR_DATA);
   assign status_rd = bus.Rd && (bus.Address == ADDR_STATUS);
   assign full      = (count_reg == (FIFO_AW + 1)'(DEPTH));
   assign baud_done = (baud_reg == BW'(CLKS_PER_BIT - 1));
   assign head      = fifo_mem[rd_ptr_reg];
   assign unused_hi = ^bus.Data_out[15:8];

   // Pops are decided from registered count only, so a fresh push waits one edge.
   assign pop     = (count_reg != '0) &&
                    ((state_reg == S_IDLE) || ((state_reg == S_STOP) && baud_done));
   assign push_ok = push_req && (!full || pop);

   assign Busy        = (state_reg != S_IDLE) || (count_reg != '0);
   assign Tx          = tx_reg;
   assign bus.Sel     = status_rd;
   assign bus.Rd_data = status_rd ? {13'b0, overflow_reg, full, Busy} : 16'h0000;

   always_ff @(posedge Clk) begin
      if (push_ok)
         fifo_mem[wr_ptr_reg] <= bus.Data_out[7:0];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
         state_reg    <= S_IDLE;
         baud_reg     <= '0;
         bit_reg      <= '0;
         shift_reg    <= '0;
         parity_reg   <= 1'b0;
         tx_reg       <= 1'b1;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase

         // A dropped byte on the same edge as a status read keeps the flag set.
         if (push_req && full && !pop)
            overflow_reg <= 1'b1;
         else if (status_rd)
            overflow_reg <= 1'b0;

         if (state_reg == S_IDLE) begin
            baud_reg <= '0;
            tx_reg   <= 1'b1;
            if (pop) begin
               shift_reg  <= head;
               parity_reg <= ^head;
               bit_reg    <= '0;
               tx_reg     <= 1'b0;
               state_reg  <= S_START;
            end
         end else if (!baud_done) begin
            baud_reg <= baud_reg + 1'b1;
         end else begin
            baud_reg <= '0;
            case (state_reg)
               S_START: begin
                  tx_reg    <= shift_reg[0];
                  state_reg <= S_DATA;
               end
               S_DATA: begin
                  if (bit_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                     tx_reg    <= parity_reg;
                     state_reg <= S_PARITY;
`else
                     tx_reg    <= 1'b1;
                     state_reg <= S_STOP;
`endif
                  end else begin
                     bit_reg   <= bit_reg + 1'b1;
                     shift_reg <= shift_reg >> 1;
                     tx_reg    <= shift_reg[1];
                  end
               end
`ifdef UART_PARITY_EN
               S_PARITY: begin
                  tx_reg    <= 1'b1;
                  state_reg <= S_STOP;
               end
`endif
               S_STOP: begin
                  // Chain straight into the next start bit when bytes are waiting.
                  if (pop) begin
                     shift_reg  <= head;
                     parity_reg <= ^head;
                     bit_reg    <= '0;
                     tx_reg     <= 1'b0;
                     state_reg  <= S_START;
                  end else begin
                     tx_reg    <= 1'b1;
                     state_reg <= S_IDLE;
                  end
               end
               default: begin
                  tx_reg    <= 1'b1;
                  state_reg <= S_IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mu0_uart_tx.sv
// Self-checking bench for mu0_uart_tx: per-cycle Tx/Busy waveform checks plus a
// serial-line decoder feeding a byte scoreboard.
module tb_mu0_uart_tx;
   localparam int CPB = 4;
`ifdef UART_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME = FRAME_BITS * CPB;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tx;
   logic busy;
   mu0_uart_tx_if bus();

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_bytes [256];
   logic       rx_stop_ok [256];
   logic       rx_par_ok [256];
   int         rx_count = 0;
   int         rx_seen = 0;

   always #5 clk = ~clk;

   mu0_uart_tx #(
      .ADDR_DATA(12'hFF0), .ADDR_STATUS(12'hFF1), .CLKS_PER_BIT(CPB), .FIFO_AW(2)
   ) dut (
      .Clk(clk), .Reset(reset), .bus(bus), .Tx(tx), .Busy(busy)
   );

   // Expected line level k cycles after the edge that popped the byte (k>=1).
   function automatic logic exp_tx(input logic [7:0] b, input int k);
      int j;
      j = (k - 1) / CPB;
      if (j == 0) return 1'b0;
      if (j <= 8) return b[j-1];
      if (FRAME_BITS == 11 && j == 9) return ^b;
      return 1'b1;
   endfunction

   // Serial decoder: samples each bit in its middle and records decoded bytes.
   initial begin : monitor
      bit         hunting;
      int         off;
      int         idx;
      logic [7:0] sh;
      logic       par;
      hunting = 1'b1;
      off = 0;
      sh = '0;
      par = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            hunting = 1'b1;
         end else if (hunting) begin
            if (tx === 1'b0) begin
               hunting = 1'b0;
               off = 0;
            end
         end else begin
            off++;
            if (off % CPB == CPB / 2) begin
               idx = off / CPB;
               if (idx >= 1 && idx <= 8) begin
                  sh[idx-1] = tx;
               end else if (FRAME_BITS == 11 && idx == 9) begin
                  par = tx;
               end else if (idx == FRAME_BITS - 1) begin
                  rx_bytes[rx_count % 256]   = sh;
                  rx_stop_ok[rx_count % 256] = (tx === 1'b1);
                  rx_par_ok[rx_count % 256]  = (FRAME_BITS == 10) || (par === ^sh);
                  rx_count++;
                  hunting = 1'b1;
               end
            end
         end
      end
   end

   task automatic bus_idle();
      bus.Address  = 12'h000;
      bus.Data_out = 16'h0000;
      bus.Wr       = 1'b0;
      bus.Rd       = 1'b0;
   endtask

   task automatic set_write(input logic [7:0] b);
      bus.Address  = 12'hFF0;
      bus.Data_out = {8'hA5, b};
      bus.Wr       = 1'b1;
      bus.Rd       = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus_idle();
      repeat (2) @(negedge clk);
      tests_run++;
      if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx got=%b exp=1", tx); end
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
      bus.Rd = 1'b1;
      bus.Address = 12'hFF1;
      #1;
      tests_run++;
      if (bus.Sel !== 1'b1 || bus.Rd_data !== 16'h0000) begin
         tests_failed++;
         $display("FAIL reset_status sel=%b data=%h exp sel=1 data=0000", bus.Sel, bus.Rd_data);
      end
      @(negedge clk);
      reset = 1'b0;
      bus.Address = 12'h010;
      #1;
      tests_run++;
      if (bus.Sel !== 1'b0 || bus.Rd_data !== 16'h0000) begin
         tests_failed++;
         $display("FAIL other_addr_read sel=%b data=%h exp sel=0 data=0000", bus.Sel, bus.Rd_data);
      end
      bus_idle();
      @(negedge clk);
      $display("[TB] test_reset done");
   endtask

   task automatic test_frame(input logic [7:0] b, input string name);
      int bad_tx;
      int bad_busy;
      @(negedge clk);
      set_write(b);
      exp_q.push_back(b);
      @(negedge clk);
      bus_idle();
      tests_run++;
      if (tx !== 1'b1 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_after_push tx=%b busy=%b exp tx=1 busy=1", name, tx, busy);
      end
      bad_tx = 0;
      bad_busy = 0;
      for (int k = 1; k <= FRAME + 2; k++) begin
         @(negedge clk);
         if (tx !== exp_tx(b, k)) begin
            bad_tx++;
            $display("FAIL %s_tx cycle=%0d got=%b exp=%b", name, k, tx, exp_tx(b, k));
         end
         if (busy !== (k <= FRAME)) begin
            bad_busy++;
            $display("FAIL %s_busy cycle=%0d got=%b exp=%b", name, k, busy, (k <= FRAME));
         end
      end
      tests_run += 2;
      if (bad_tx != 0) tests_failed++;
      if (bad_busy != 0) tests_failed++;
      while (exp_q.size() > 0) begin
         tests_run++;
         if (rx_seen >= rx_count) begin
            tests_failed++;
            $display("FAIL %s_rx_missing got=none exp=%h", name, exp_q[0]);
            exp_q.delete();
         end else begin
            if (rx_bytes[rx_seen % 256] !== exp_q[0] || !rx_stop_ok[rx_seen % 256] ||
                !rx_par_ok[rx_seen % 256]) begin
               tests_failed++;
               $display("FAIL %s_rx_byte got=%h exp=%h", name, rx_bytes[rx_seen % 256], exp_q[0]);
            end
            void'(exp_q.pop_front());
            rx_seen++;
         end
      end
      $display("[TB] %s done: byte %h", name, b);
   endtask

   task automatic test_overflow();
      int waited;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         set_write(8'h11 + 8'(i));
         if (i < 5) exp_q.push_back(8'h11 + 8'(i));
      end
      @(negedge clk);
      bus.Wr = 1'b0;
      bus.Rd = 1'b1;
      bus.Address = 12'hFF1;
      #1;
      tests_run++;
      if (bus.Sel !== 1'b1 || bus.Rd_data !== 16'h0007) begin
         tests_failed++;
         $display("FAIL overflow_status got=%h exp=0007", bus.Rd_data);
      end
      @(negedge clk);
      #1;
      tests_run++;
      if (bus.Rd_data !== 16'h0003) begin
         tests_failed++;
         $display("FAIL overflow_cleared got=%h exp=0003", bus.Rd_data);
      end
      bus_idle();
      #1;
      tests_run++;
      if (bus.Sel !== 1'b0 || bus.Rd_data !== 16'h0000) begin
         tests_failed++;
         $display("FAIL no_read_status sel=%b data=%h exp sel=0 data=0000", bus.Sel, bus.Rd_data);
      end
      waited = 0;
      while (busy === 1'b1 && waited < 8 * FRAME) begin
         @(negedge clk);
         waited++;
      end
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL overflow_drain_timeout busy=%b exp=0", busy);
      end
      repeat (2) @(negedge clk);
      while (exp_q.size() > 0) begin
         tests_run++;
         if (rx_seen >= rx_count) begin
            tests_failed++;
            $display("FAIL overflow_rx_missing got=none exp=%h", exp_q[0]);
            exp_q.delete();
         end else begin
            if (rx_bytes[rx_seen % 256] !== exp_q[0] || !rx_stop_ok[rx_seen % 256] ||
                !rx_par_ok[rx_seen % 256]) begin
               tests_failed++;
               $display("FAIL overflow_rx_byte got=%h exp=%h", rx_bytes[rx_seen % 256], exp_q[0]);
            end
            void'(exp_q.pop_front());
            rx_seen++;
         end
      end
      tests_run++;
      if (rx_count != rx_seen) begin
         tests_failed++;
         $display("FAIL overflow_extra_frames got=%0d exp=%0d", rx_count, rx_seen);
      end
      bus.Rd = 1'b1;
      bus.Address = 12'hFF1;
      #1;
      tests_run++;
      if (bus.Rd_data !== 16'h0000) begin
         tests_failed++;
         $display("FAIL overflow_final_status got=%h exp=0000", bus.Rd_data);
      end
      @(negedge clk);
      bus_idle();
      $display("[TB] test_overflow done: 6 writes, 5 frames");
   endtask

   task automatic test_back_to_back();
      logic [7:0] a;
      logic [7:0] b;
      logic       e;
      int         bad_tx;
      a = 8'hA1;
      b = 8'hB2;
      @(negedge clk);
      set_write(a);
      exp_q.push_back(a);
      @(negedge clk);
      set_write(b);
      exp_q.push_back(b);
      bad_tx = 0;
      for (int k = 1; k <= 2 * FRAME + 2; k++) begin
         @(negedge clk);
         if (k == 1) bus_idle();
         if (k <= FRAME) e = exp_tx(a, k);
         else if (k <= 2 * FRAME) e = exp_tx(b, k - FRAME);
         else e = 1'b1;
         if (tx !== e) begin
            bad_tx++;
            $display("FAIL b2b_tx cycle=%0d got=%b exp=%b", k, tx, e);
         end
      end
      tests_run++;
      if (bad_tx != 0) tests_failed++;
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_busy_end got=%b exp=0", busy);
      end
      while (exp_q.size() > 0) begin
         tests_run++;
         if (rx_seen >= rx_count) begin
            tests_failed++;
            $display("FAIL b2b_rx_missing got=none exp=%h", exp_q[0]);
            exp_q.delete();
         end else begin
            if (rx_bytes[rx_seen % 256] !== exp_q[0] || !rx_stop_ok[rx_seen % 256] ||
                !rx_par_ok[rx_seen % 256]) begin
               tests_failed++;
               $display("FAIL b2b_rx_byte got=%h exp=%h", rx_bytes[rx_seen % 256], exp_q[0]);
            end
            void'(exp_q.pop_front());
            rx_seen++;
         end
      end
      $display("[TB] test_back_to_back done: A1 then B2");
   endtask

   task automatic test_reset_mid_frame();
      int rx_before;
      int bad;
      @(negedge clk); set_write(8'hFF);
      @(negedge clk); set_write(8'h33);
      @(negedge clk); set_write(8'h44);
      @(negedge clk); bus_idle();
      repeat (14) @(negedge clk);
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL midframe_busy_before got=%b exp=1", busy);
      end
      rx_before = rx_count;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests_run++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL midframe_reset tx=%b busy=%b exp tx=1 busy=0", tx, busy);
      end
      bus.Rd = 1'b1;
      bus.Address = 12'hFF1;
      #1;
      tests_run++;
      if (bus.Rd_data !== 16'h0000) begin
         tests_failed++;
         $display("FAIL midframe_status got=%h exp=0000", bus.Rd_data);
      end
      @(negedge clk);
      bus_idle();
      bad = 0;
      for (int k = 0; k < 3 * FRAME; k++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL midframe_line_quiet got=%0d active cycles exp=0", bad);
      end
      tests_run++;
      if (rx_count != rx_before) begin
         tests_failed++;
         $display("FAIL midframe_no_frames got=%0d frames exp=%0d", rx_count, rx_before);
      end
      exp_q.delete();
      rx_seen = rx_count;
      $display("[TB] test_reset_mid_frame done");
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      bus_idle();
      test_reset();
      test_frame(8'h55, "frame55");
      test_overflow();
      test_back_to_back();
      test_reset_mid_frame();
      test_frame(8'h3C, "frame3c");
`ifdef UART_PARITY_EN
      test_frame(8'h07, "parity07");
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
